// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, imem request/ack handshake, and a
// held instruction register split into OPCODE / flagbit / IMM.
// Latency: ack -> instr_valid next edge; instr_done -> new imem_req next edge.
// Backpressure: imem_req holds with a stable address until acked; the held
// instruction stays valid until execute pulses instr_done.
// Ports: CLK/RST_N; imem_req/imem_addr/imem_ack/imem_rdata memory side;
// instr_valid/OPCODE/flagbit/IMM/PC to decode; instr_done/PCWrite/PCNext from
// execute; fetch_fault sticky timeout flag.
// Optional macro FETCH_TIMEOUT_EN: enables the fetch-wait timeout and the
// FAULT state (fetch_fault is tied 0 otherwise).
module instr_fetch #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          TIMEOUT  = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  output logic [4:0]        OPCODE,
  output logic              flagbit,
  output logic [9:0]        IMM,
  output logic [ADDR_W-1:0] PC,
  input  logic              instr_done,
  input  logic              PCWrite,
  input  logic [ADDR_W-1:0] PCNext,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [15:0]       instr_q, instr_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_FETCH: begin
        // An ack in the final wait cycle still wins over the timeout.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_HOLD: begin
        if (instr_done) begin
          pc_d    = PCWrite ? PCNext : (pc_q + ADDR_W'(1));
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_FAULT: begin
        state_d = S_FAULT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign instr_valid = valid_q;
  assign OPCODE      = instr_q[15:11];
  assign flagbit     = instr_q[10];
  assign IMM         = instr_q[9:0];
`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
